writeback_arbiter: RTL and testbench

//   Consumer end of the X->W interface. Collects results from p_num_x execute units (ALU, MUL, MEM, ...),

---
 rtl/writeback_arbiter.sv | 154 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: consumer end of the X->W interface.
// Picks one execute-unit result per cycle (round-robin starting at ptr), holds it
// in a single-entry W register, and from there writes the regfile, notifies
// commit and frees the previous physical register on the commit handshake.
// Optional feature: define WRITEBACK_BYPASS_EN to add the byp_* forwarding outputs.
module writeback_arbiter #(
   parameter int p_num_x          = 3,
   parameter int p_seq_num_bits   = 5,
   parameter int p_phys_addr_bits = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [p_num_x-1:0]                   x_val,
   output logic [p_num_x-1:0]                   x_rdy,
   input  logic [p_num_x*32-1:0]                x_pc,
   input  logic [p_num_x*p_seq_num_bits-1:0]    x_seq_num,
   input  logic [p_num_x*5-1:0]                 x_waddr,
   input  logic [p_num_x*32-1:0]                x_wdata,
   input  logic [p_num_x-1:0]                   x_wen,
   input  logic [p_num_x*p_phys_addr_bits-1:0]  x_preg,
   input  logic [p_num_x*p_phys_addr_bits-1:0]  x_ppreg,
   output logic                                 rf_wen,
   output logic [p_phys_addr_bits-1:0]          rf_waddr,
   output logic [31:0]                          rf_wdata,
   output logic                                 cm_val,
   input  logic                                 cm_rdy,
   output logic [31:0]                          cm_pc,
   output logic [p_seq_num_bits-1:0]            cm_seq_num,
   output logic [4:0]                           cm_waddr,
`ifdef WRITEBACK_BYPASS_EN
   output logic                                 byp_val,
   output logic [p_phys_addr_bits-1:0]          byp_preg,
   output logic [31:0]                          byp_data,
`endif
   output logic                                 free_val,
   output logic [p_phys_addr_bits-1:0]          free_preg
);

   localparam int SEQ   = p_seq_num_bits;
   localparam int PHYS  = p_phys_addr_bits;
   localparam int PTR_W = (p_num_x > 1) ? $clog2(p_num_x) : 1;

   // W register and round-robin pointer
   logic              w_val_q,   w_val_d;
   logic [31:0]       w_pc_q,    w_pc_d;
   logic [SEQ-1:0]    w_seq_q,   w_seq_d;
   logic [4:0]        w_waddr_q, w_waddr_d;
   logic [31:0]       w_wdata_q, w_wdata_d;
   logic              w_wen_q,   w_wen_d;
   logic [PHYS-1:0]   w_preg_q,  w_preg_d;
   logic [PHYS-1:0]   w_ppreg_q, w_ppreg_d;
   logic [PTR_W-1:0]  ptr_q,     ptr_d;

   logic              accept;
   logic              grant;
   logic [PTR_W-1:0]  gnt_idx;
   logic              wr_ok;

   // Round-robin grant: first valid unit scanning from ptr; accept never looks at x_rdy
   always_comb begin
      int idx;
      idx     = 0;
      accept  = !w_val_q || cm_rdy;
      grant   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < p_num_x; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= p_num_x) idx = idx - p_num_x;
         if (!grant && x_val[idx]) begin
            grant   = 1'b1;
            gnt_idx = PTR_W'(idx);
         end
      end
      // A held result under reset must not be replaced, and no unit may see a handshake
      grant = grant && accept && !rst;
      x_rdy = '0;
      if (grant) x_rdy[gnt_idx] = 1'b1;
   end

   // Next state of W and ptr: load on grant (fill and drain may coincide), else drain on commit
   always_comb begin
      w_val_d   = w_val_q;
      w_pc_d    = w_pc_q;
      w_seq_d   = w_seq_q;
      w_waddr_d = w_waddr_q;
      w_wdata_d = w_wdata_q;
      w_wen_d   = w_wen_q;
      w_preg_d  = w_preg_q;
      w_ppreg_d = w_ppreg_q;
      ptr_d     = ptr_q;
      if (grant) begin
         w_val_d   = 1'b1;
         w_pc_d    = x_pc[int'(gnt_idx)*32 +: 32];
         w_seq_d   = x_seq_num[int'(gnt_idx)*SEQ +: SEQ];
         w_waddr_d = x_waddr[int'(gnt_idx)*5 +: 5];
         w_wdata_d = x_wdata[int'(gnt_idx)*32 +: 32];
         w_wen_d   = x_wen[gnt_idx];
         w_preg_d  = x_preg[int'(gnt_idx)*PHYS +: PHYS];
         w_ppreg_d = x_ppreg[int'(gnt_idx)*PHYS +: PHYS];
         ptr_d     = (gnt_idx == PTR_W'(p_num_x - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end else if (w_val_q && cm_rdy) begin
         w_val_d   = 1'b0;
      end
   end

   // State update; reset clears every W field so outputs read 0 until the first transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         w_val_q   <= 1'b0;
         w_pc_q    <= '0;
         w_seq_q   <= '0;
         w_waddr_q <= '0;
         w_wdata_q <= '0;
         w_wen_q   <= 1'b0;
         w_preg_q  <= '0;
         w_ppreg_q <= '0;
         ptr_q     <= '0;
      end else begin
         w_val_q   <= w_val_d;
         w_pc_q    <= w_pc_d;
         w_seq_q   <= w_seq_d;
         w_waddr_q <= w_waddr_d;
         w_wdata_q <= w_wdata_d;
         w_wen_q   <= w_wen_d;
         w_preg_q  <= w_preg_d;
         w_ppreg_q <= w_ppreg_d;
         ptr_q     <= ptr_d;
      end
   end

   // Commit, regfile write and free all fire on the single handshake cycle; r0 writes are dropped
   always_comb begin
      wr_ok      = w_val_q && cm_rdy && w_wen_q && (w_waddr_q != 5'd0) && !rst;
      cm_val     = w_val_q && !rst;
      cm_pc      = w_pc_q;
      cm_seq_num = w_seq_q;
      cm_waddr   = w_waddr_q;
      rf_wen     = wr_ok;
      rf_waddr   = w_preg_q;
      rf_wdata   = w_wdata_q;
      free_val   = wr_ok;
      free_preg  = w_ppreg_q;
   end

`ifdef WRITEBACK_BYPASS_EN
   // Forward the pending result to issue regardless of commit back-pressure
   always_comb begin
      byp_val  = w_val_q && w_wen_q && (w_waddr_q != 5'd0) && !rst;
      byp_preg = w_preg_q;
      byp_data = w_wdata_q;
   end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter (p_num_x=3): scoreboard of expected commits
// plus per-scenario inline checks of grants and handshake outputs.
module tb_writeback_arbiter;

   localparam int N    = 3;
   localparam int SEQ  = 5;
   localparam int PHYS = 6;

   logic clk;
   logic rst;
   logic [N-1:0]      x_val, x_rdy, x_wen;
   logic [N*32-1:0]   x_pc, x_wdata;
   logic [N*SEQ-1:0]  x_seq_num;
   logic [N*5-1:0]    x_waddr;
   logic [N*PHYS-1:0] x_preg, x_ppreg;
   logic              rf_wen, cm_val, cm_rdy, free_val;
   logic [PHYS-1:0]   rf_waddr, free_preg;
   logic [31:0]       rf_wdata, cm_pc;
   logic [SEQ-1:0]    cm_seq_num;
   logic [4:0]        cm_waddr;
`ifdef WRITEBACK_BYPASS_EN
   logic              byp_val;
   logic [PHYS-1:0]   byp_preg;
   logic [31:0]       byp_data;
`endif

   logic [31:0]     s_pc[N];
   logic [SEQ-1:0]  s_seq[N];
   logic [4:0]      s_waddr[N];
   logic [31:0]     s_wdata[N];
   logic [PHYS-1:0] s_preg[N];
   logic [PHYS-1:0] s_ppreg[N];

   typedef struct {
      logic [31:0]     pc;
      logic [SEQ-1:0]  seq;
      logic [4:0]      waddr;
      logic [31:0]     wdata;
      logic [PHYS-1:0] preg;
      logic [PHYS-1:0] ppreg;
      logic            rfw;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   mptr;
   bit   mwval;
   int   n_cmp = 0;
   int   n_fail = 0;

   writeback_arbiter #(.p_num_x(N), .p_seq_num_bits(SEQ), .p_phys_addr_bits(PHYS)) dut (
      .clk(clk), .rst(rst),
      .x_val(x_val), .x_rdy(x_rdy), .x_pc(x_pc), .x_seq_num(x_seq_num),
      .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wen(x_wen),
      .x_preg(x_preg), .x_ppreg(x_ppreg),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .cm_val(cm_val), .cm_rdy(cm_rdy), .cm_pc(cm_pc),
      .cm_seq_num(cm_seq_num), .cm_waddr(cm_waddr),
`ifdef WRITEBACK_BYPASS_EN
      .byp_val(byp_val), .byp_preg(byp_preg), .byp_data(byp_data),
`endif
      .free_val(free_val), .free_preg(free_preg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-unit stimulus into the flat buses
   always_comb begin
      for (int i = 0; i < N; i++) begin
         x_pc[i*32 +: 32]       = s_pc[i];
         x_seq_num[i*SEQ +: SEQ] = s_seq[i];
         x_waddr[i*5 +: 5]      = s_waddr[i];
         x_wdata[i*32 +: 32]    = s_wdata[i];
         x_preg[i*PHYS +: PHYS]  = s_preg[i];
         x_ppreg[i*PHYS +: PHYS] = s_ppreg[i];
      end
   end

   // Scoreboard: every commit handshake pops the oldest expected result
   always @(negedge clk) begin
      if (cm_val === 1'b1 && cm_rdy === 1'b1) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL commit_unexpected: got pc=%h seq=%0d, required no commit", cm_pc, cm_seq_num);
         end else begin
            mon_e = q.pop_front();
            if ({cm_pc, cm_seq_num, cm_waddr} !== {mon_e.pc, mon_e.seq, mon_e.waddr}) begin
               n_fail++;
               $display("FAIL commit_id: got pc=%h seq=%0d waddr=%0d, required pc=%h seq=%0d waddr=%0d",
                        cm_pc, cm_seq_num, cm_waddr, mon_e.pc, mon_e.seq, mon_e.waddr);
            end
            n_cmp++;
            if (rf_wen !== mon_e.rfw || free_val !== mon_e.rfw) begin
               n_fail++;
               $display("FAIL commit_wen: got rf_wen=%b free_val=%b, required %b", rf_wen, free_val, mon_e.rfw);
            end
            n_cmp++;
            if (rf_waddr !== mon_e.preg || rf_wdata !== mon_e.wdata || free_preg !== mon_e.ppreg) begin
               n_fail++;
               $display("FAIL commit_data: got preg=%0d data=%h ppreg=%0d, required preg=%0d data=%h ppreg=%0d",
                        rf_waddr, rf_wdata, free_preg, mon_e.preg, mon_e.wdata, mon_e.ppreg);
            end
         end
      end
   end

   // Reference arbiter decision for the current inputs (-1 = no grant)
   function automatic int model_gnt();
      int idx;
      if (rst || !(!mwval || cm_rdy)) return -1;
      for (int k = 0; k < N; k++) begin
         idx = (mptr + k) % N;
         if (x_val[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int g);
      logic [N-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic set_unit(input int u, input logic [31:0] pc, input logic [SEQ-1:0] sq,
                           input logic [4:0] wa, input logic [31:0] wd, input logic wen,
                           input logic [PHYS-1:0] pr, input logic [PHYS-1:0] ppr);
      s_pc[u] = pc; s_seq[u] = sq; s_waddr[u] = wa; s_wdata[u] = wd;
      x_wen[u] = wen; s_preg[u] = pr; s_ppreg[u] = ppr;
   endtask

   // Advance the model by one edge (pushing any granted result), then move to posedge+1
   task automatic step();
      int g;
      exp_t e;
      g = model_gnt();
      if (rst) begin
         q.delete();
         mptr = 0;
         mwval = 0;
      end else if (g >= 0) begin
         e.pc = s_pc[g]; e.seq = s_seq[g]; e.waddr = s_waddr[g]; e.wdata = s_wdata[g];
         e.preg = s_preg[g]; e.ppreg = s_ppreg[g];
         e.rfw = x_wen[g] && (s_waddr[g] != 5'd0);
         q.push_back(e);
         mptr = (g + 1) % N;
         mwval = 1;
      end else if (mwval && cm_rdy) begin
         mwval = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cm_rdy = 1'b0; x_val = '0; x_wen = '0;
      for (int u = 0; u < N; u++) set_unit(u, 32'h0, '0, 5'd0, 32'h0, 1'b0, '0, '0);
      step();
      step();
      @(negedge clk);
      n_cmp++;
      if ({x_rdy, cm_val, rf_wen, free_val} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got x_rdy=%b cm_val=%b rf_wen=%b free_val=%b, required all 0",
                  x_rdy, cm_val, rf_wen, free_val);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({x_rdy, cm_val, rf_wen, free_val} !== '0) begin
         n_fail++;
         $display("FAIL post_reset_ctrl: got x_rdy=%b cm_val=%b rf_wen=%b free_val=%b, required all 0",
                  x_rdy, cm_val, rf_wen, free_val);
      end
      n_cmp++;
      if (cm_pc !== 32'h0 || cm_seq_num !== '0 || cm_waddr !== 5'd0 ||
          rf_waddr !== '0 || rf_wdata !== 32'h0 || free_preg !== '0) begin
         n_fail++;
         $display("FAIL post_reset_data: got pc=%h seq=%0d wa=%0d preg=%0d data=%h ppreg=%0d, required all 0",
                  cm_pc, cm_seq_num, cm_waddr, rf_waddr, rf_wdata, free_preg);
      end
      step();
   endtask

   task automatic test_round_robin();
      int exp_g[6] = '{0, 1, 2, 0, 1, 2};
      cm_rdy = 1'b1;
      x_val  = 3'b111;
      for (int c = 0; c < 6; c++) begin
         for (int u = 0; u < N; u++)
            set_unit(u, 32'h1000 + 32'(c*16 + u*4), SEQ'(c*3 + u), 5'(u + 1),
                     32'hA000_0000 + 32'(c*16 + u), 1'b1, PHYS'(10 + u), PHYS'(20 + u));
         @(negedge clk);
         n_cmp++;
         if (x_rdy !== onehot(exp_g[c])) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got x_rdy=%b, required %b", c, x_rdy, onehot(exp_g[c]));
         end
         if (c > 0) begin
            n_cmp++;
            if (cm_val !== 1'b1) begin
               n_fail++;
               $display("FAIL rr_throughput[%0d]: got cm_val=%b, required 1", c, cm_val);
            end
         end
         step();
      end
      x_val = '0;
      @(negedge clk);
      step();
   endtask

   task automatic test_single();
      cm_rdy = 1'b1;
      set_unit(1, 32'h0000_0400, SEQ'(7), 5'd5, 32'h1234, 1'b1, PHYS'(9), PHYS'(3));
      x_val = 3'b010;
      @(negedge clk);
      n_cmp++;
      if (x_rdy !== 3'b010) begin
         n_fail++;
         $display("FAIL single_grant: got x_rdy=%b, required 010", x_rdy);
      end
      step();
      x_val = '0;
      @(negedge clk);
      n_cmp++;
      if (rf_wen !== 1'b1 || rf_waddr !== PHYS'(9) || rf_wdata !== 32'h1234 ||
          free_val !== 1'b1 || free_preg !== PHYS'(3)) begin
         n_fail++;
         $display("FAIL single_write: got wen=%b preg=%0d data=%h free=%b ppreg=%0d, required 1 9 1234 1 3",
                  rf_wen, rf_waddr, rf_wdata, free_val, free_preg);
      end
      step();
   endtask

   task automatic test_backpressure();
      int g;
      logic [31:0] h_pc;
      logic [SEQ-1:0] h_seq;
      cm_rdy = 1'b1;
      for (int u = 0; u < N; u++)
         set_unit(u, 32'h2000 + 32'(u*4), SEQ'(16 + u), 5'(8 + u), 32'hB000_0000 + 32'(u),
                  1'b1, PHYS'(30 + u), PHYS'(40 + u));
      x_val = 3'b111;
      @(negedge clk);
      g = model_gnt();
      h_pc = s_pc[g];
      h_seq = s_seq[g];
      n_cmp++;
      if (x_rdy !== onehot(g)) begin
         n_fail++;
         $display("FAIL bp_fill_grant: got x_rdy=%b, required %b", x_rdy, onehot(g));
      end
      step();
      cm_rdy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int u = 0; u < N; u++) s_pc[u] = s_pc[u] + 32'h100;
         @(negedge clk);
         n_cmp++;
         if (x_rdy !== '0 || rf_wen !== 1'b0 || free_val !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_rdy[%0d]: got x_rdy=%b rf_wen=%b free=%b, required 0 0 0", c, x_rdy, rf_wen, free_val);
         end
         n_cmp++;
         if (cm_val !== 1'b1 || cm_pc !== h_pc || cm_seq_num !== h_seq) begin
            n_fail++;
            $display("FAIL bp_hold_w[%0d]: got val=%b pc=%h seq=%0d, required 1 %h %0d", c, cm_val, cm_pc, cm_seq_num, h_pc, h_seq);
         end
         step();
      end
      cm_rdy = 1'b1;
      @(negedge clk);
      g = model_gnt();
      n_cmp++;
      if (x_rdy !== onehot(g) || x_rdy === '0 || rf_wen !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: got x_rdy=%b rf_wen=%b, required %b 1", x_rdy, rf_wen, onehot(g));
      end
      step();
      x_val = '0;
      @(negedge clk);
      n_cmp++;
      if (cm_val !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_refill: got cm_val=%b, required 1", cm_val);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (cm_val !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got cm_val=%b, required 0", cm_val);
      end
      step();
   endtask

   task automatic test_no_write();
      cm_rdy = 1'b1;
      set_unit(0, 32'h3000, SEQ'(25), 5'd0, 32'hDEAD_0000, 1'b1, PHYS'(50), PHYS'(51));
      set_unit(2, 32'h3004, SEQ'(26), 5'd7, 32'hBEEF_0000, 1'b0, PHYS'(52), PHYS'(53));
      for (int c = 0; c < 2; c++) begin
         x_val = (c == 0) ? 3'b001 : 3'b100;
         @(negedge clk);
         n_cmp++;
         if (x_rdy !== x_val) begin
            n_fail++;
            $display("FAIL nowr_grant[%0d]: got x_rdy=%b, required %b", c, x_rdy, x_val);
         end
         step();
         x_val = '0;
         @(negedge clk);
         n_cmp++;
         if (cm_val !== 1'b1 || rf_wen !== 1'b0 || free_val !== 1'b0) begin
            n_fail++;
            $display("FAIL nowr_commit[%0d]: got cm_val=%b rf_wen=%b free=%b, required 1 0 0", c, cm_val, rf_wen, free_val);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      cm_rdy = 1'b1;
      for (int u = 0; u < N; u++)
         set_unit(u, 32'h4000 + 32'(u*4), SEQ'(u + 1), 5'(12 + u), 32'hC000_0000 + 32'(u),
                  1'b1, PHYS'(u + 1), PHYS'(u + 4));
      x_val = 3'b111;
      @(negedge clk);
      step();
      cm_rdy = 1'b0;
      x_val = '0;
      @(negedge clk);
      n_cmp++;
      if (cm_val !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_held: got cm_val=%b, required 1", cm_val);
      end
      step();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cm_val !== 1'b0 || rf_wen !== 1'b0 || free_val !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_during: got cm_val=%b rf_wen=%b free=%b, required 0 0 0", cm_val, rf_wen, free_val);
      end
      step();
      rst = 1'b0;
      cm_rdy = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cm_val !== 1'b0 || rf_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_after: got cm_val=%b rf_wen=%b, required 0 0", cm_val, rf_wen);
      end
      step();
      x_val = 3'b111;
      @(negedge clk);
      n_cmp++;
      if (x_rdy !== 3'b001) begin
         n_fail++;
         $display("FAIL rmid_ptr: got x_rdy=%b, required 001", x_rdy);
      end
      step();
      x_val = '0;
      @(negedge clk);
      step();
      @(negedge clk);
      step();
   endtask

   initial begin
      rst = 1'b1;
      cm_rdy = 1'b0;
      x_val = '0;
      x_wen = '0;
      mptr = 0;
      mwval = 0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_no_write();
      test_reset_mid();
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d results never committed, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
